// File: rtl/stream_mux_rr.sv
// stream_mux_rr
//  N-channel, WIDTH-bit stream multiplexer with a one-entry registered output
//  stage and valid/ready handshake on both sides. MODE 0 picks the channel
//  from an external select; MODE 1 arbitrates round-robin across channels.
//
//  Optional feature (macro STREAM_MUX_XFER_CNT_EN): adds xfer_cnt, a 16-bit
//  saturating count of output transfers (out_valid & out_ready).
//
//  Ports
//   clk        rising-edge clock
//   rst_n      asynchronous reset, active low
//   in_data    NCHAN*WIDTH, channel k at [k*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel accept, one-hot or zero
//   sel        channel select (MODE 0 only)
//   out_data   registered selected data
//   out_chan   channel index that supplied out_data
//   out_valid  out_data/out_chan valid
//   out_ready  consumer accept
//   xfer_cnt   output transfer count (only with STREAM_MUX_XFER_CNT_EN)
module stream_mux_rr #(
  parameter int WIDTH = 4,
  parameter int NCHAN = 4,
  parameter int MODE  = 1,
  localparam int SW   = $clog2(NCHAN)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NCHAN*WIDTH-1:0] in_data,
  input  logic [NCHAN-1:0]       in_valid,
  output logic [NCHAN-1:0]       in_ready,
  input  logic [SW-1:0]          sel,
  output logic [WIDTH-1:0]       out_data,
  output logic [SW-1:0]          out_chan,
  output logic                   out_valid,
  input  logic                   out_ready
`ifdef STREAM_MUX_XFER_CNT_EN
  ,
  output logic [15:0]            xfer_cnt
`endif
);

  logic [WIDTH-1:0] data_reg;
  logic [SW-1:0]    chan_reg;
  logic             valid_reg;
  logic [SW-1:0]    ptr_reg;
  logic [SW-1:0]    ptr_next;

  logic             load;
  logic             xfer;
  logic             grant_vld;
  logic [SW-1:0]    grant_idx;
  logic [WIDTH-1:0] chan_data [NCHAN];

  // Output register may be refilled whenever it is empty or being drained.
  assign load = !valid_reg | out_ready;
  // Gating with rst_n keeps every in_ready low while reset is held.
  assign xfer = load & grant_vld & rst_n;

  genvar gi;
  generate
    for (gi = 0; gi < NCHAN; gi++) begin : g_chan
      assign chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
      assign in_ready[gi]  = xfer & (grant_idx == SW'(gi));
    end

    if (MODE == 0) begin : g_sel_mode
      // Comparing against each legal index means an out-of-range sel
      // simply matches nothing, so no grant is given.
      always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NCHAN; k++) begin
          if (sel == SW'(k) && in_valid[k]) begin
            grant_vld = 1'b1;
            grant_idx = SW'(k);
          end
        end
      end
      logic unused_ptr;
      assign unused_ptr = ^ptr_next;
    end else begin : g_rr_mode
      // Scan ptr, ptr+1, ... with wrap; first requester found wins.
      always_comb begin
        int idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int k = 0; k < NCHAN; k++) begin
          idx = int'(ptr_reg) + k;
          if (idx >= NCHAN) idx = idx - NCHAN;
          if (!grant_vld && in_valid[idx]) begin
            grant_vld = 1'b1;
            grant_idx = SW'(idx);
          end
        end
      end
      logic unused_sel;
      assign unused_sel = ^sel;
    end
  endgenerate

  // Pointer moves just past the channel that was served.
  assign ptr_next = (grant_idx == SW'(NCHAN-1)) ? '0 : grant_idx + SW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg  <= '0;
      chan_reg  <= '0;
      valid_reg <= 1'b0;
      ptr_reg   <= '0;
    end else if (load) begin
      valid_reg <= grant_vld;
      if (grant_vld) begin
        data_reg <= chan_data[grant_idx];
        chan_reg <= grant_idx;
        if (MODE != 0) ptr_reg <= ptr_next;
      end
    end
  end

  assign out_data  = data_reg;
  assign out_chan  = chan_reg;
  assign out_valid = valid_reg;

`ifdef STREAM_MUX_XFER_CNT_EN
  logic [15:0] cnt_reg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (valid_reg && out_ready && cnt_reg != 16'hFFFF) begin
      cnt_reg <= cnt_reg + 16'd1;
    end
  end
  assign xfer_cnt = cnt_reg;
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: a round-robin instance (NCHAN=4),
// an external-select instance (NCHAN=4) and an external-select instance
// with NCHAN=3 for the out-of-range select case.
module tb_stream_mux_rr;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Round-robin instance
  logic [15:0] rr_in_data = '0;
  logic [3:0]  rr_in_valid = '0;
  logic [3:0]  rr_in_ready;
  logic [1:0]  rr_sel = '0;
  logic [3:0]  rr_out_data;
  logic [1:0]  rr_out_chan;
  logic        rr_out_valid;
  logic        rr_out_ready = 1'b0;

  // External-select instance, 4 channels
  logic [15:0] m0_in_data = '0;
  logic [3:0]  m0_in_valid = '0;
  logic [3:0]  m0_in_ready;
  logic [1:0]  m0_sel = '0;
  logic [3:0]  m0_out_data;
  logic [1:0]  m0_out_chan;
  logic        m0_out_valid;
  logic        m0_out_ready = 1'b0;

  // External-select instance, 3 channels
  logic [11:0] m3_in_data = '0;
  logic [2:0]  m3_in_valid = '0;
  logic [2:0]  m3_in_ready;
  logic [1:0]  m3_sel = '0;
  logic [3:0]  m3_out_data;
  logic [1:0]  m3_out_chan;
  logic        m3_out_valid;
  logic        m3_out_ready = 1'b0;

`ifdef STREAM_MUX_XFER_CNT_EN
  logic [15:0] rr_xfer_cnt, m0_xfer_cnt, m3_xfer_cnt;
`endif

  stream_mux_rr #(.WIDTH(4), .NCHAN(4), .MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .in_data(rr_in_data), .in_valid(rr_in_valid),
    .in_ready(rr_in_ready), .sel(rr_sel), .out_data(rr_out_data),
    .out_chan(rr_out_chan), .out_valid(rr_out_valid), .out_ready(rr_out_ready)
`ifdef STREAM_MUX_XFER_CNT_EN
    , .xfer_cnt(rr_xfer_cnt)
`endif
  );

  stream_mux_rr #(.WIDTH(4), .NCHAN(4), .MODE(0)) u_m0 (
    .clk(clk), .rst_n(rst_n), .in_data(m0_in_data), .in_valid(m0_in_valid),
    .in_ready(m0_in_ready), .sel(m0_sel), .out_data(m0_out_data),
    .out_chan(m0_out_chan), .out_valid(m0_out_valid), .out_ready(m0_out_ready)
`ifdef STREAM_MUX_XFER_CNT_EN
    , .xfer_cnt(m0_xfer_cnt)
`endif
  );

  stream_mux_rr #(.WIDTH(4), .NCHAN(3), .MODE(0)) u_m3 (
    .clk(clk), .rst_n(rst_n), .in_data(m3_in_data), .in_valid(m3_in_valid),
    .in_ready(m3_in_ready), .sel(m3_sel), .out_data(m3_out_data),
    .out_chan(m3_out_chan), .out_valid(m3_out_valid), .out_ready(m3_out_ready)
`ifdef STREAM_MUX_XFER_CNT_EN
    , .xfer_cnt(m3_xfer_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      $display("[TB] ok   %s: %0h", tag, obs);
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst rr out_valid", 32'(rr_out_valid), 0);
    check("rst rr out_data", 32'(rr_out_data), 0);
    check("rst rr out_chan", 32'(rr_out_chan), 0);
    check("rst m0 out_valid", 32'(m0_out_valid), 0);
    rst_n = 1'b1;

    // Round-robin: all channels requesting, data = channel+1
    rr_in_data   = 16'h4321;
    rr_in_valid  = 4'b1111;
    rr_out_ready = 1'b1;
    #1 check("rr first in_ready", 32'(rr_in_ready), 32'h1);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check($sformatf("rr rot%0d valid", i), 32'(rr_out_valid), 1);
      check($sformatf("rr rot%0d chan", i), 32'(rr_out_chan), 32'(i % 4));
      check($sformatf("rr rot%0d data", i), 32'(rr_out_data), 32'((i % 4) + 1));
      check($sformatf("rr rot%0d in_ready", i), 32'(rr_in_ready), 32'(1 << ((i + 1) % 4)));
    end

    // Wrap: pointer now at 3, only ch3 and ch0 requesting
    rr_in_valid = 4'b1001;
    #1 check("rr wrap in_ready", 32'(rr_in_ready), 32'h8);
    @(negedge clk);
    check("rr wrap chan3", 32'(rr_out_chan), 3);
    check("rr wrap data3", 32'(rr_out_data), 4);
    check("rr wrap in_ready0", 32'(rr_in_ready), 32'h1);
    @(negedge clk);
    check("rr wrap chan0", 32'(rr_out_chan), 0);
    check("rr wrap data0", 32'(rr_out_data), 1);
    rr_in_valid = 4'b0000;
    @(negedge clk);
    check("rr drain valid", 32'(rr_out_valid), 0);
`ifdef STREAM_MUX_XFER_CNT_EN
    check("rr xfer_cnt", 32'(rr_xfer_cnt), 9);
`endif

    // External select: sel=2
    m0_sel       = 2'd2;
    m0_in_valid  = 4'b0100;
    m0_in_data   = 16'h0A00;
    m0_out_ready = 1'b1;
    #1 check("m0 sel2 in_ready", 32'(m0_in_ready), 32'h4);
    @(negedge clk);
    check("m0 sel2 valid", 32'(m0_out_valid), 1);
    check("m0 sel2 data", 32'(m0_out_data), 32'hA);
    check("m0 sel2 chan", 32'(m0_out_chan), 2);

    // Backpressure: next word B waits while A is stalled
    m0_out_ready = 1'b0;
    m0_in_data   = 16'h0B00;
    #1 check("m0 bp in_ready", 32'(m0_in_ready), 0);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        m0_sel      = 2'd0;
        m0_in_valid = 4'b0101;
      end
      @(negedge clk);
      check($sformatf("m0 bp%0d data", i), 32'(m0_out_data), 32'hA);
      check($sformatf("m0 bp%0d chan", i), 32'(m0_out_chan), 2);
      check($sformatf("m0 bp%0d valid", i), 32'(m0_out_valid), 1);
      check($sformatf("m0 bp%0d in_ready", i), 32'(m0_in_ready), 0);
    end
    m0_sel       = 2'd2;
    m0_in_valid  = 4'b0100;
    m0_out_ready = 1'b1;
    #1 check("m0 release in_ready", 32'(m0_in_ready), 32'h4);
    @(negedge clk);
    check("m0 release data", 32'(m0_out_data), 32'hB);
    check("m0 release chan", 32'(m0_out_chan), 2);
    m0_in_valid = 4'b0000;
    @(negedge clk);
    check("m0 drain valid", 32'(m0_out_valid), 0);

    // NCHAN=3: load ch1, then select out-of-range 3
    m3_sel       = 2'd1;
    m3_in_valid  = 3'b010;
    m3_in_data   = 12'h050;
    m3_out_ready = 1'b1;
    @(negedge clk);
    check("m3 sel1 data", 32'(m3_out_data), 32'h5);
    check("m3 sel1 chan", 32'(m3_out_chan), 1);
    m3_sel      = 2'd3;
    m3_in_valid = 3'b111;
    #1 check("m3 sel3 in_ready", 32'(m3_in_ready), 0);
    @(negedge clk);
    check("m3 sel3 valid", 32'(m3_out_valid), 0);
    check("m3 sel3 in_ready2", 32'(m3_in_ready), 0);

    // Asynchronous reset mid-stream
    rr_in_valid  = 4'b0001;
    rr_out_ready = 1'b0;
    @(negedge clk);
    check("rr pre-rst valid", 32'(rr_out_valid), 1);
    check("rr pre-rst data", 32'(rr_out_data), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rr async rst valid", 32'(rr_out_valid), 0);
    check("rr async rst data", 32'(rr_out_data), 0);
    check("rr async rst chan", 32'(rr_out_chan), 0);
    check("rr rst in_ready", 32'(rr_in_ready), 0);
    @(negedge clk);
    rst_n        = 1'b1;
    rr_in_valid  = 4'b1111;
    rr_out_ready = 1'b1;
    #1 check("rr ptr after rst", 32'(rr_in_ready), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
